// File: rtl/fetch_unit_if.sv
// Bus bundle for the fetch stage: instruction-memory read port plus the
// valid/ready handoff towards decode. The master side is the fetch unit.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  // Instruction-memory read port
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  // Decode handoff
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              dec_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output instr_valid,
    output instr,
    output instr_pc,
    input  dec_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output dec_ready
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: captures the PC, reads instruction memory over a
// req/ack handshake with wait states, and hands the word to decode under
// valid/ready. Flushed responses are discarded; halt is sticky until reset.
module fetch_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] programCounter,
  input  logic              flush,
  input  logic              halt,
  output logic              pc_advance,
  fetch_unit_if.master      bus,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StFull,
    StHalted
  } state_e;

  state_e            state_q, state_d;
  logic              imem_req_q, imem_req_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic              instr_valid_q, instr_valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              pc_advance_q, pc_advance_d;
  logic              halted_q, halted_d;
  logic [31:0]       fetch_count_q, fetch_count_d;
  logic              drop_q, drop_d;
  logic              halt_pend_q, halt_pend_d;

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    imem_req_d    = imem_req_q;
    imem_addr_d   = imem_addr_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    pc_advance_d  = 1'b0;
    halted_d      = halted_q;
    fetch_count_d = fetch_count_q;
    drop_d        = drop_q;
    halt_pend_d   = halt_pend_q;

    unique case (state_q)
      StIdle: begin
        // A pending halt can reach IDLE through a flush out of FULL
        if (halt || halt_pend_q) begin
          state_d  = StHalted;
          halted_d = 1'b1;
        end else begin
          imem_addr_d  = programCounter;
          imem_req_d   = 1'b1;
          pc_advance_d = 1'b1;
          state_d      = StReq;
        end
      end

      StReq: begin
        // The request is never withdrawn; a flush only marks the reply stale
        if (flush) drop_d = 1'b1;
        if (halt) halt_pend_d = 1'b1;
        if (bus.imem_ack) begin
          imem_req_d = 1'b0;
          if (drop_q || flush) begin
            drop_d = 1'b0;
            if (halt_pend_q || halt) begin
              state_d  = StHalted;
              halted_d = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            instr_d       = bus.imem_rdata;
            instr_pc_d    = imem_addr_q;
            instr_valid_d = 1'b1;
            state_d       = StFull;
          end
        end
      end

      StFull: begin
        if (flush) begin
          // Flush wins over a simultaneous dec_ready: nothing is handed off
          instr_valid_d = 1'b0;
          state_d       = StIdle;
          if (halt) halt_pend_d = 1'b1;
        end else if (bus.dec_ready) begin
          fetch_count_d = fetch_count_q + 32'd1;
          instr_valid_d = 1'b0;
          if (halt || halt_pend_q) begin
            state_d  = StHalted;
            halted_d = 1'b1;
          end else begin
            imem_addr_d  = programCounter;
            imem_req_d   = 1'b1;
            pc_advance_d = 1'b1;
            state_d      = StReq;
          end
        end else if (halt) begin
          halt_pend_d = 1'b1;
        end
      end

      StHalted: begin
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
        halted_d      = 1'b1;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      pc_advance_q  <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
      drop_q        <= 1'b0;
      halt_pend_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      pc_advance_q  <= pc_advance_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
      drop_q        <= drop_d;
      halt_pend_q   <= halt_pend_d;
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign pc_advance      = pc_advance_q;
  assign halted          = halted_q;
  assign fetch_count     = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of fetch transactions chained
// back-to-back, followed by hand-written flush, halt, reset and wrap sequences.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic [31:0] programCounter;
  logic        flush;
  logic        halt;
  logic        pc_advance;
  logic        halted;
  logic [31:0] fetch_count;

  int n_cmp;
  int n_err;

  fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  fetch_unit #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .programCounter(programCounter),
    .flush         (flush),
    .halt          (halt),
    .pc_advance    (pc_advance),
    .bus           (bus),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    int          waits;
    logic [31:0] rdata;
    int          stall;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic [31:0] exp_count;
  } vec_t;

  localparam int NVec = 4;
  vec_t vec [NVec];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_out(input string tag);
    chk({tag, " req"}, 32'(bus.imem_req), 32'd0);
    chk({tag, " valid"}, 32'(bus.instr_valid), 32'd0);
    chk({tag, " pc_adv"}, 32'(pc_advance), 32'd0);
  endtask

  initial begin
    logic [31:0] npc;
    n_cmp = 0;
    n_err = 0;

    //            pc            waits rdata         stall exp_instr     exp_pc        count
    vec[0] = '{32'h0000_0010, 0, 32'hA5A5_0001, 4, 32'hA5A5_0001, 32'h0000_0010, 32'd1};
    vec[1] = '{32'h0000_0020, 3, 32'h1234_5678, 0, 32'h1234_5678, 32'h0000_0020, 32'd2};
    vec[2] = '{32'h0000_0044, 1, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 32'h0000_0044, 32'd3};
    vec[3] = '{32'hFFFF_FFFC, 0, 32'h0000_0000, 1, 32'h0000_0000, 32'hFFFF_FFFC, 32'd4};

    reset          = 1'b0;
    programCounter = 32'h0;
    flush          = 1'b0;
    halt           = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.dec_ready  = 1'b0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk_idle_out("rst");
    chk("rst addr", bus.imem_addr, 32'h0);
    chk("rst instr", bus.instr, 32'h0);
    chk("rst instr_pc", bus.instr_pc, 32'h0);
    chk("rst halted", 32'(halted), 32'd0);
    chk("rst count", fetch_count, 32'd0);

    @(negedge clock);
    reset          = 1'b1;
    programCounter = vec[0].pc;
    tick();
    chk("first req", 32'(bus.imem_req), 32'd1);
    chk("first addr", bus.imem_addr, vec[0].pc);
    chk("first pc_adv", 32'(pc_advance), 32'd1);

    // Chained transactions: each starts in the first REQ cycle
    for (int i = 0; i < NVec; i++) begin
      npc = (i == NVec - 1) ? 32'h0000_0030 : vec[i + 1].pc;
      programCounter = 32'h5555_0000 + 32'(i);  // must not disturb held addr
      for (int w = 0; w < vec[i].waits; w++) begin
        bus.imem_ack = 1'b0;
        tick();
        chk($sformatf("v%0d wait req", i), 32'(bus.imem_req), 32'd1);
        chk($sformatf("v%0d wait addr", i), bus.imem_addr, vec[i].pc);
        chk($sformatf("v%0d wait pc_adv", i), 32'(pc_advance), 32'd0);
        chk($sformatf("v%0d wait valid", i), 32'(bus.instr_valid), 32'd0);
      end
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = vec[i].rdata;
      tick();
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'h0BAD_0BAD;
      chk($sformatf("v%0d valid", i), 32'(bus.instr_valid), 32'd1);
      chk($sformatf("v%0d instr", i), bus.instr, vec[i].exp_instr);
      chk($sformatf("v%0d instr_pc", i), bus.instr_pc, vec[i].exp_pc);
      chk($sformatf("v%0d req drop", i), 32'(bus.imem_req), 32'd0);
      for (int s = 0; s < vec[i].stall; s++) begin
        bus.dec_ready = 1'b0;
        tick();
        chk($sformatf("v%0d hold valid", i), 32'(bus.instr_valid), 32'd1);
        chk($sformatf("v%0d hold instr", i), bus.instr, vec[i].exp_instr);
        chk($sformatf("v%0d hold pc_adv", i), 32'(pc_advance), 32'd0);
      end
      bus.dec_ready  = 1'b1;
      programCounter = npc;
      tick();
      bus.dec_ready  = 1'b0;
      chk($sformatf("v%0d count", i), fetch_count, vec[i].exp_count);
      chk($sformatf("v%0d next req", i), 32'(bus.imem_req), 32'd1);
      chk($sformatf("v%0d next addr", i), bus.imem_addr, npc);
      chk($sformatf("v%0d next pc_adv", i), 32'(pc_advance), 32'd1);
      chk($sformatf("v%0d valid clr", i), 32'(bus.instr_valid), 32'd0);
    end

    // Flush in the 2nd wait cycle of the 0x30 fetch
    tick();
    chk("fl w1 req", 32'(bus.imem_req), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl w2 req held", 32'(bus.imem_req), 32'd1);
    chk("fl w2 addr", bus.imem_addr, 32'h30);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hBAAD_0030;
    programCounter = 32'h80;
    tick();
    bus.imem_ack = 1'b0;
    chk_idle_out("fl ack");
    tick();
    chk("fl refetch req", 32'(bus.imem_req), 32'd1);
    chk("fl refetch addr", bus.imem_addr, 32'h80);
    chk("fl refetch pc_adv", 32'(pc_advance), 32'd1);
    chk("fl no count", fetch_count, 32'd4);

    // Flush beats dec_ready in FULL
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h1111_0080;
    tick();
    bus.imem_ack = 1'b0;
    chk("ff instr_pc", bus.instr_pc, 32'h80);
    flush         = 1'b1;
    bus.dec_ready = 1'b1;
    tick();
    flush         = 1'b0;
    bus.dec_ready = 1'b0;
    chk_idle_out("ff flush");
    chk("ff no count", fetch_count, 32'd4);
    programCounter = 32'h90;
    tick();
    chk("ff refetch addr", bus.imem_addr, 32'h90);
    chk("ff refetch pc_adv", 32'(pc_advance), 32'd1);

    // Flush coinciding with the ack discards the word
    flush          = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hBAAD_0090;
    tick();
    flush        = 1'b0;
    bus.imem_ack = 1'b0;
    chk_idle_out("fa ack");
    programCounter = 32'hA0;
    tick();
    chk("fa refetch addr", bus.imem_addr, 32'hA0);

    // Halt during REQ: deliver the in-flight word once, then halt
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("h req held", 32'(bus.imem_req), 32'd1);
    chk("h not yet", 32'(halted), 32'd0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hCAFE_00A0;
    tick();
    bus.imem_ack = 1'b0;
    chk("h valid", 32'(bus.instr_valid), 32'd1);
    chk("h instr", bus.instr, 32'hCAFE_00A0);
    bus.dec_ready = 1'b1;
    tick();
    chk("h count", fetch_count, 32'd5);
    chk("h halted", 32'(halted), 32'd1);
    chk_idle_out("h after");
    for (int k = 0; k < 5; k++) begin
      bus.imem_ack  = 1'b1;
      bus.dec_ready = 1'b1;
      flush         = k[0];
      tick();
      chk("h stay halted", 32'(halted), 32'd1);
      chk_idle_out("h stay");
    end
    bus.imem_ack  = 1'b0;
    bus.dec_ready = 1'b0;
    flush         = 1'b0;

    // Asynchronous reset out of HALTED
    reset = 1'b0;
    #1;
    chk("ar halted", 32'(halted), 32'd0);
    chk("ar count", fetch_count, 32'd0);
    chk("ar instr", bus.instr, 32'h0);
    chk_idle_out("ar");
    @(negedge clock);
    reset          = 1'b1;
    programCounter = 32'hB0;
    tick();
    chk("ar refetch addr", bus.imem_addr, 32'hB0);
    chk("ar refetch req", 32'(bus.imem_req), 32'd1);

    // Reset mid-REQ drops the request immediately; halt from IDLE afterwards
    reset = 1'b0;
    #1;
    chk("mr req", 32'(bus.imem_req), 32'd0);
    chk("mr addr", bus.imem_addr, 32'h0);
    halt = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    tick();
    halt = 1'b0;
    chk("ih halted", 32'(halted), 32'd1);
    chk_idle_out("ih");

    // Counter wrap via preloaded value
    reset = 1'b0;
    #1;
    @(negedge clock);
    reset          = 1'b1;
    programCounter = 32'hC0;
    tick();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0C0C_0C0C;
    tick();
    bus.imem_ack = 1'b0;
    chk("wr valid", 32'(bus.instr_valid), 32'd1);
    force dut.fetch_count_q = 32'hFFFF_FFFF;
    tick();
    release dut.fetch_count_q;
    bus.dec_ready  = 1'b1;
    programCounter = 32'hD0;
    tick();
    bus.dec_ready = 1'b0;
    chk("wr count wrap", fetch_count, 32'd0);
    chk("wr next addr", bus.imem_addr, 32'hD0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
